// File: rtl/rfphoenix_mc_wb_buffer_pkg.sv
// Shared types for the multi-cycle ALU writeback path.
// The ALU and the writeback buffer take their result latency from MC_ALU_LAT.
package rfphoenix_mc_wb_buffer_pkg;

  localparam int TID_W      = 4;
  localparam int MC_RWID    = 6;
  localparam int MC_ALU_LAT = 8;

  typedef logic [TID_W-1:0] tid_t;
  typedef logic [63:0]      double_value_t;

  // One queued register-file write.
  typedef struct packed {
    tid_t                tid;
    logic [MC_RWID-1:0]  rt;
    double_value_t       res;
  } mcwb_entry_t;

endpackage

// File: rtl/rfphoenix_sync_fifo.sv
// Synchronous-reset FIFO with a registered head, occupancy count and push/pop.
// The head is read from storage registers, so a push into an empty FIFO
// shows up on dout/valid one cycle later. dout is zero while empty.
module rfphoenix_sync_fifo #(
  parameter int WID   = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WID-1:0]                 din,
  input  logic                           pop,
  output logic [WID-1:0]                 dout,
  output logic                           valid,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WID-1:0] mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign valid   = (count != '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign dout    = valid ? mem[rd_ptr] : '0;

  // Storage write; contents need no reset because dout is gated by valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally (power-of-two depth); full/empty come from count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Upstream credit accounting must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/rfphoenix_mc_wb_buffer.sv
// Writeback buffer behind the multi-cycle ALU. Each accepted op drops a
// {tid, rt} tag into an LAT-stage shift pipe; when the tag emerges the ALU
// result is captured with it into a FIFO feeding the register-file write port.
// A credit counter covers ops in flight plus queued results, so issue is
// throttled before the FIFO could ever overflow.
//
// Handshakes: a transfer happens in a cycle exactly when valid && ready are
// both high at the rising edge. issue_rdy never depends on issue_v or wb_rdy;
// wb_v and the head fields never depend on wb_rdy and hold stable while
// wb_v && !wb_rdy.
module rfphoenix_mc_wb_buffer
  import rfphoenix_mc_wb_buffer_pkg::*;
#(
  parameter int LAT   = MC_ALU_LAT,
  parameter int DEPTH = 8,
  parameter int RWID  = MC_RWID
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_v,
  input  tid_t                          issue_tid,
  input  logic [RWID-1:0]               issue_rt,
  output logic                          issue_rdy,
  input  double_value_t                 alu_o,
  input  tid_t                          alu_rido,
  output logic                          wb_v,
  input  logic                          wb_rdy,
  output tid_t                          wb_tid,
  output logic [RWID-1:0]               wb_rt,
  output double_value_t                 wb_res,
  output logic [$clog2(DEPTH+1)-1:0]    used,
  output logic                          err_tag
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $bits(tid_t);
  localparam int EW = TW + RWID + 64;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic            accept;
  logic            pop;
  logic [CW-1:0]   used_q;

  logic            pipe_v   [LAT];
  tid_t            pipe_tid [LAT];
  logic [RWID-1:0] pipe_rt  [LAT];

  logic            cap_v;
  tid_t            cap_tid;
  logic [RWID-1:0] cap_rt;

  logic [EW-1:0]   fifo_din;
  logic [EW-1:0]   fifo_dout;
  logic            fifo_full;
  logic [CW-1:0]   fifo_count;

  // Credit is taken from the registered counter only.
  assign issue_rdy = !rst && (used_q < DEPTH_C);
  assign accept    = issue_v && issue_rdy;
  assign pop       = wb_v && wb_rdy;
  assign used      = used_q;

  // Pipe output lines up with the ALU result for the same op.
  assign cap_v    = pipe_v[LAT-1];
  assign cap_tid  = pipe_tid[LAT-1];
  assign cap_rt   = pipe_rt[LAT-1];
  assign fifo_din = {cap_tid, cap_rt, alu_o};

  // Tag pipe: a rejected or absent op enters as a bubble; reset flushes all tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_tid[i] <= '0;
        pipe_rt[i]  <= '0;
      end
    end else begin
      pipe_v[0]   <= accept;
      pipe_tid[0] <= issue_tid;
      pipe_rt[0]  <= issue_rt;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tid[i] <= pipe_tid[i-1];
        pipe_rt[i]  <= pipe_rt[i-1];
      end
    end
  end

  // Credit counter: in-flight plus queued; accept and pop together cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      used_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   used_q <= used_q + CW'(1);
        2'b01:   used_q <= used_q - CW'(1);
        default: used_q <= used_q;
      endcase
    end
  end

  // Sticky tag error: the ALU's delayed tid disagrees with the tracked one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_tag <= 1'b0;
    end else if (cap_v && (alu_rido != cap_tid)) begin
      err_tag <= 1'b1;
    end
  end

  rfphoenix_sync_fifo #(
    .WID   (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap_v),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (wb_v),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign wb_tid = fifo_dout[EW-1 -: TW];
  assign wb_rt  = fifo_dout[64 +: RWID];
  assign wb_res = fifo_dout[63:0];

  // Queued results can never outnumber the credits held for them.
  a_count_le_used: assert property (@(posedge clk) disable iff (rst) fifo_count <= used_q);
  a_no_cap_full:   assert property (@(posedge clk) disable iff (rst) !(cap_v && fifo_full));

endmodule

// File: tb/tb_rfphoenix_mc_wb_buffer.sv
// Directed bench for the multi-cycle ALU writeback buffer. A small ALU model
// replays scheduled results LAT cycles after each issue; a monitor compares
// every presented head entry against the expected queue.
module tb_rfphoenix_mc_wb_buffer;
  import rfphoenix_mc_wb_buffer_pkg::*;

  localparam int LAT   = 8;
  localparam int DEPTH = 8;
  localparam int RWID  = 6;
  localparam int EW    = TID_W + RWID + 64;

  logic            clk;
  logic            rst;
  logic            issue_v;
  tid_t            issue_tid;
  logic [RWID-1:0] issue_rt;
  logic            issue_rdy;
  double_value_t   alu_o;
  tid_t            alu_rido;
  logic            wb_v;
  logic            wb_rdy;
  tid_t            wb_tid;
  logic [RWID-1:0] wb_rt;
  double_value_t   wb_res;
  logic [3:0]      used;
  logic            err_tag;

  rfphoenix_mc_wb_buffer #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .RWID  (RWID)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .issue_v   (issue_v),
    .issue_tid (issue_tid),
    .issue_rt  (issue_rt),
    .issue_rdy (issue_rdy),
    .alu_o     (alu_o),
    .alu_rido  (alu_rido),
    .wb_v      (wb_v),
    .wb_rdy    (wb_rdy),
    .wb_tid    (wb_tid),
    .wb_rt     (wb_rt),
    .wb_res    (wb_res),
    .used      (used),
    .err_tag   (err_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- ALU model ----------------
  int            cyc = 0;
  double_value_t sched_res  [int];
  tid_t          sched_rido [int];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (sched_res.exists(cyc)) begin
      alu_o    = sched_res[cyc];
      alu_rido = sched_rido[cyc];
    end else begin
      alu_o    = {$urandom, $urandom};
      alu_rido = tid_t'($urandom_range(0, 15));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Present an op this cycle; when it is expected to be accepted, schedule the
  // ALU result LAT cycles out and record the expected writeback entry.
  task automatic drive_issue(input tid_t t, input logic [RWID-1:0] r, input double_value_t res,
                             input tid_t rido, input bit expect_accept);
    issue_v   = 1'b1;
    issue_tid = t;
    issue_rt  = r;
    if (expect_accept) begin
      sched_res[cyc + LAT]  = res;
      sched_rido[cyc + LAT] = rido;
      exp_q.push_back({t, r, res});
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", EW'(exp_q.size()), '0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && wb_v) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", EW'(wb_v), '0);
      end else begin
        chk("wb_entry", {wb_tid, wb_rt, wb_res}, exp_q[0]);
        if (wb_rdy) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    issue_v   = 1'b1;
    issue_tid = 4'd1;
    issue_rt  = 6'd1;
    wb_rdy    = 1'b0;
    alu_o     = '0;
    alu_rido  = '0;

    // 1: reset with issue_v held high
    repeat (2) begin
      step();
      at_neg();
      chk("rst_issue_rdy", EW'(issue_rdy), '0);
      chk("rst_used", EW'(used), '0);
      chk("rst_wb_v", EW'(wb_v), '0);
      chk("rst_wb_fields", {wb_tid, wb_rt, wb_res}, '0);
    end
    step();
    rst     = 1'b0;
    issue_v = 1'b0;
    at_neg();
    chk("post_rst_issue_rdy", EW'(issue_rdy), EW'(1));
    chk("post_rst_used", EW'(used), '0);
    chk("post_rst_wb_v", EW'(wb_v), '0);
    chk("post_rst_err", EW'(err_tag), '0);

    // 2: single op, result appears at T+9
    step();
    wb_rdy = 1'b1;
    drive_issue(4'd3, 6'd5, 64'h4000_0000_0000_0000, 4'd3, 1'b1);
    at_neg();
    chk("single_issue_rdy", EW'(issue_rdy), EW'(1));
    for (int i = 1; i <= LAT; i++) begin
      step();
      issue_v = 1'b0;
      at_neg();
      chk("single_used_inflight", EW'(used), EW'(1));
      chk("single_wb_v_early", EW'(wb_v), '0);
    end
    step();
    at_neg();
    chk("single_wb_v", EW'(wb_v), EW'(1));
    chk("single_used_head", EW'(used), EW'(1));
    step();
    at_neg();
    chk("single_used_after_pop", EW'(used), '0);
    chk("single_wb_v_after_pop", EW'(wb_v), '0);

    // 3: credits exhausted with the write port stalled
    wb_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      drive_issue(tid_t'(i), 6'(10 + i), 64'h1111_0000_0000_0000 + 64'(i * 3), tid_t'(i), 1'b1);
      at_neg();
      chk("credit_issue_rdy", EW'(issue_rdy), EW'(1));
    end
    for (int i = 0; i < 9; i++) begin
      step();
      drive_issue(4'hE, 6'd40, 64'hDEAD_BEEF_0000_0001, 4'hE, 1'b0);
      at_neg();
      chk("credit_full_issue_rdy", EW'(issue_rdy), '0);
      chk("credit_full_used", EW'(used), EW'(DEPTH));
    end

    // 4: pop and issue together while full: no credit this cycle
    step();
    wb_rdy = 1'b1;
    at_neg();
    chk("simul_issue_rdy", EW'(issue_rdy), '0);
    chk("simul_used", EW'(used), EW'(DEPTH));
    chk("simul_wb_v", EW'(wb_v), EW'(1));
    step();
    drive_issue(4'hE, 6'd40, 64'hDEAD_BEEF_0000_0001, 4'hE, 1'b1);
    at_neg();
    chk("simul_next_used", EW'(used), EW'(DEPTH - 1));
    chk("simul_next_issue_rdy", EW'(issue_rdy), EW'(1));
    step();
    issue_v = 1'b0;
    drain(40);
    step();
    at_neg();
    chk("credit_drained_used", EW'(used), '0);

    // 5: tag mismatch at capture
    step();
    drive_issue(4'd2, 6'd7, 64'h3FF0_0000_0000_0000, 4'd1, 1'b1);
    at_neg();
    chk("tag_err_before", EW'(err_tag), '0);
    for (int i = 1; i <= LAT; i++) begin
      step();
      issue_v = 1'b0;
      at_neg();
    end
    chk("tag_err_at_capture", EW'(err_tag), '0);
    step();
    at_neg();
    chk("tag_err_set", EW'(err_tag), EW'(1));
    repeat (5) step();
    at_neg();
    chk("tag_err_sticky", EW'(err_tag), EW'(1));
    chk("tag_drained", EW'(exp_q.size()), '0);

    // 6: reset with four ops in flight
    for (int i = 0; i < 4; i++) begin
      step();
      drive_issue(tid_t'(8 + i), 6'(20 + i), 64'hA5A5_0000_0000_0000 + 64'(i), tid_t'(8 + i), 1'b1);
      at_neg();
    end
    step();
    issue_v = 1'b0;
    rst     = 1'b1;
    exp_q.delete();
    at_neg();
    chk("midrst_issue_rdy", EW'(issue_rdy), '0);
    step();
    rst = 1'b0;
    at_neg();
    chk("midrst_used", EW'(used), '0);
    chk("midrst_wb_v", EW'(wb_v), '0);
    chk("midrst_err_clear", EW'(err_tag), '0);
    chk("midrst_issue_rdy_back", EW'(issue_rdy), EW'(1));
    for (int i = 0; i < 14; i++) begin
      step();
      at_neg();
      chk("midrst_no_wb", EW'(wb_v), '0);
    end
    chk("midrst_used_idle", EW'(used), '0);
    step();
    drive_issue(4'd5, 6'd9, 64'hC000_0000_0000_0000, 4'd5, 1'b1);
    at_neg();
    step();
    issue_v = 1'b0;
    drain(20);
    step();
    at_neg();
    chk("fresh_used_final", EW'(used), '0);
    chk("fresh_err_clear", EW'(err_tag), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
